hub75_scan_engine: RTL and testbench
====================================

// Module: hub75_scan_engine
// PURPOSE
//  Parametrised HUB75 scan generator. Drives column/row/bit-plane sequencing for the LED matrix with binary-coded modulation.
//  Shifts the next slot while the current one displays. Adds configurable fetch latency, ghosting dead-time and a frame pulse.
//  Sits between the clock divider and framebuffer_fetch/pixel_split. Replaces the fixed 64x32 / 6-bit scanner.
// PARAMETERS
//  COLUMNS         64  pixels shifted per row (>=2)
//  ROW_ADDR_WIDTH  4   row address bits; scan rows = 2**ROW_ADDR_WIDTH
//  BITPLANES       6   colour bit-planes per row (1..8)
//  BASE_ON_CYCLES  1   OE-on clk_in cycles for plane 0; plane p = BASE_ON_CYCLES<<p
//  FETCH_LATENCY   2   clk_in cycles from clk_pixel_load to valid pixel data
//  DEAD_CYCLES     1   OE-low guard cycles before and after each latch (0 allowed)
// PORTS
//  clk_in              in   1               scan clock
//  reset               in   1               asynchronous, active-low reset
//  enable              in   1               0: output_enable forced low; sequencing continues
//  column_address      out  clog2(COLUMNS)  column being fetched/shifted
//  row_address         out  ROW_ADDR_WIDTH  row being fetched/shifted
//  row_address_active  out  ROW_ADDR_WIDTH  row currently displayed (panel A..D)
//  brightness_mask     out  BITPLANES       one-hot plane displayed
//  clk_pixel_load      out  1               1-cycle pulse: start fetch of column_address
//  clk_pixel           out  1               panel shift clock
//  row_latch           out  1               panel latch strobe
//  output_enable       out  1               active-high OE (inverted at the pin)
//  frame_start         out  1               1-cycle pulse when row 0 / plane 0 is latched
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0. Display counter reads "done". Shift of slot (row 0, plane 0) starts on the first cycle after release.
//  Slot order: plane 0..BITPLANES-1 inner loop, then row 0..2**W-1. Wraps to row 0 / plane 0 after the last slot.
//  Shift path, per column: period = FETCH_LATENCY+2 cycles.
//   - Cycle 0: clk_pixel_load=1 and column_address updated.
//   - clk_pixel=0 for cycles 0..FETCH_LATENCY; clk_pixel=1 on the final cycle.
//   - After COLUMNS periods: shift_done=1, column_address holds COLUMNS-1, shifter idles.
//  Display/latch FSM: IDLE -> BLANK -> LATCH -> UNBLANK -> DISPLAY -> IDLE.
//   - IDLE: wait for shift_done && display_done. Both may become true in the same cycle.
//   - BLANK: DEAD_CYCLES cycles, OE low. Skipped if DEAD_CYCLES=0.
//   - LATCH: 1 cycle with row_latch=1.
//       - row_address_active <= row_address; brightness_mask <= 1<<plane.
//       - frame_start=1 if the slot is row 0 / plane 0.
//       - Slot counter advances; the next shift starts on the following cycle.
//   - UNBLANK: DEAD_CYCLES cycles, OE low.
//   - DISPLAY: counter 0..on_time-1. output_enable = enable during count; display_done on reaching on_time.
//  Counter widths: on-time counter >= ROW-independent width clog2(BASE_ON_CYCLES<<(BITPLANES-1))+1. No truncation permitted.
//  Short planes: on_time < shift time -> FSM waits in IDLE with OE low. Long planes: shifter waits idle.
//  enable change mid-DISPLAY takes effect next cycle. It never stalls counters.
//  Reset mid-operation: all state cleared immediately. The partial shift is discarded and the scan restarts at row 0 / plane 0.
// CONFIGURATION
//  SCAN_GLOBAL_DIM_EN defined:
//   - Adds input dim [7:0], sampled in LATCH.
//   - on_time = max(1, ((BASE_ON_CYCLES<<p)*(dim+1))>>8); product computed at full width.
//  Undefined: no dim port; on_time = BASE_ON_CYCLES<<p.
// TESTING (COLUMNS=4, ROW_ADDR_WIDTH=2, BITPLANES=3, BASE_ON_CYCLES=8, FETCH_LATENCY=1, DEAD_CYCLES=1)
//  - Reset released -> 4 clk_pixel_load pulses 3 cycles apart, 4 clk_pixel rises.
//      Then BLANK, then row_latch at cycle 14 after release.
//      Then row_address_active=0, brightness_mask=3'b001, frame_start=1.
//  - Steady state -> OE high for exactly 8/16/32 cycles for masks 001/010/100.
//      Plane 0 latch-to-latch = 15 cycles (shift-bound). Plane 2 = 35 cycles (display-bound).
//  - Run 12 slots -> row_address_active sequence 0,0,0,1,1,1,2,2,2,3,3,3, then 0.
//      frame_start pulses once per 12 latches.
//  - enable=0 during a plane-2 DISPLAY -> output_enable low the next cycle. Latch timing unchanged vs enable=1.
//  - reset asserted mid-shift (column 2) -> all outputs 0 in the same cycle.
//      After release, the sequence matches the first scenario exactly.
//  - SCAN_GLOBAL_DIM_EN, dim=127 -> on_time 4/8/16. dim=0 -> on_time 1/1/1 (clamped min). dim=255 -> 8/16/32.

Source files
------------

// File: rtl/hub75_scan_engine.sv
// HUB75 scan generator: column/row/bit-plane sequencing with binary-coded modulation, overlapped shift and display.
// Optional global dimming: define SCAN_GLOBAL_DIM_EN to add the dim[7:0] input.
module hub75_scan_engine #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int BITPLANES      = 6,
  parameter int BASE_ON_CYCLES = 1,
  parameter int FETCH_LATENCY  = 2,
  parameter int DEAD_CYCLES    = 1
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          enable,
`ifdef SCAN_GLOBAL_DIM_EN
  input  logic [7:0]                    dim,
`endif
  output logic [$clog2(COLUMNS)-1:0]    column_address,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address,
  output logic [ROW_ADDR_WIDTH-1:0]     row_address_active,
  output logic [BITPLANES-1:0]          brightness_mask,
  output logic                          clk_pixel_load,
  output logic                          clk_pixel,
  output logic                          row_latch,
  output logic                          output_enable,
  output logic                          frame_start
);

  localparam int COL_W  = $clog2(COLUMNS);
  localparam int PL_W   = (BITPLANES > 1) ? $clog2(BITPLANES) : 1;
  localparam int PH_W   = $clog2(FETCH_LATENCY + 2);
  localparam int DC_W   = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int MAX_ON = BASE_ON_CYCLES << (BITPLANES - 1);
  localparam int ON_W   = $clog2(MAX_ON) + 1;
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(FETCH_LATENCY + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(BITPLANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BLANK   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_UNBLANK = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  // With no dead time the guard states collapse straight into LATCH / DISPLAY.
  localparam state_t GAP_STATE  = HAS_DEAD ? ST_BLANK : ST_LATCH;
  localparam state_t POST_LATCH = HAS_DEAD ? ST_UNBLANK : ST_DISPLAY;

  logic                      shift_pending_r;
  logic                      shift_active_r, shift_active_s;
  logic                      shift_done_r, shift_done_s;
  logic [PH_W-1:0]           phase_r, phase_s;
  logic [COL_W-1:0]          col_r, col_s;
  logic                      load_r, pix_r;

  state_t                    state_r, state_s;
  logic [DC_W-1:0]           dead_cnt_r, dead_cnt_s;
  logic [ON_W-1:0]           disp_cnt_r, disp_cnt_s;
  logic [ON_W-1:0]           on_time_r, on_calc_s, base_on_s;
  logic                      display_done_r, display_done_s;

  logic [PL_W-1:0]           plane_r;
  logic [ROW_ADDR_WIDTH-1:0] row_r;
  logic [ROW_ADDR_WIDTH-1:0] row_active_r;
  logic [BITPLANES-1:0]      mask_r;
  logic                      latch_r, frame_r, oe_r;

`ifdef SCAN_GLOBAL_DIM_EN
  logic [ON_W+7:0]           dim_prod_s;
  logic [ON_W-1:0]           dim_scaled_s;
`endif

  // On-time of the plane about to be latched, optionally scaled by the global dim level
  always_comb begin
    base_on_s = ON_W'(BASE_ON_CYCLES) << plane_r;
`ifdef SCAN_GLOBAL_DIM_EN
    dim_prod_s   = (ON_W + 8)'(base_on_s) * (ON_W + 8)'({1'b0, dim} + 9'd1);
    dim_scaled_s = ON_W'(dim_prod_s >> 8);
    if (dim_scaled_s == {ON_W{1'b0}}) begin
      on_calc_s = ON_W'(1'b1);
    end else begin
      on_calc_s = dim_scaled_s;
    end
`else
    on_calc_s = base_on_s;
`endif
  end

  // Shift path next state: fetch/shift period of FETCH_LATENCY+2 cycles per column
  always_comb begin
    shift_active_s = shift_active_r;
    shift_done_s   = shift_done_r;
    phase_s        = phase_r;
    col_s          = col_r;
    if (shift_pending_r || (state_r == ST_LATCH)) begin
      shift_active_s = 1'b1;
      shift_done_s   = 1'b0;
      phase_s        = {PH_W{1'b0}};
      col_s          = {COL_W{1'b0}};
    end else if (shift_active_r) begin
      if (phase_r == PH_LAST) begin
        if (col_r == COL_LAST) begin
          shift_active_s = 1'b0;
          shift_done_s   = 1'b1;
        end else begin
          col_s   = col_r + COL_W'(1'b1);
          phase_s = {PH_W{1'b0}};
        end
      end else begin
        phase_s = phase_r + PH_W'(1'b1);
      end
    end else begin
      shift_active_s = 1'b0;
    end
  end

  // Shift path registers and their strobes
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      shift_pending_r <= 1'b1;
      shift_active_r  <= 1'b0;
      shift_done_r    <= 1'b0;
      phase_r         <= {PH_W{1'b0}};
      col_r           <= {COL_W{1'b0}};
      load_r          <= 1'b0;
      pix_r           <= 1'b0;
    end else begin
      shift_pending_r <= 1'b0;
      shift_active_r  <= shift_active_s;
      shift_done_r    <= shift_done_s;
      phase_r         <= phase_s;
      col_r           <= col_s;
      load_r          <= shift_active_s && (phase_s == {PH_W{1'b0}});
      pix_r           <= shift_active_s && (phase_s == PH_LAST);
    end
  end

  // Display/latch FSM next state; a plane ending with the shift already done skips IDLE
  always_comb begin
    state_s        = state_r;
    dead_cnt_s     = dead_cnt_r;
    disp_cnt_s     = disp_cnt_r;
    display_done_s = display_done_r;
    case (state_r)
      ST_IDLE: begin
        if (shift_done_r && display_done_r) begin
          state_s    = GAP_STATE;
          dead_cnt_s = {DC_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (dead_cnt_r == DC_LAST) begin
          state_s = ST_LATCH;
        end else begin
          dead_cnt_s = dead_cnt_r + DC_W'(1'b1);
        end
      end
      ST_LATCH: begin
        state_s        = POST_LATCH;
        dead_cnt_s     = {DC_W{1'b0}};
        disp_cnt_s     = {ON_W{1'b0}};
        display_done_s = 1'b0;
      end
      ST_UNBLANK: begin
        if (dead_cnt_r == DC_LAST) begin
          state_s = ST_DISPLAY;
        end else begin
          dead_cnt_s = dead_cnt_r + DC_W'(1'b1);
        end
      end
      ST_DISPLAY: begin
        if (disp_cnt_r == (on_time_r - ON_W'(1'b1))) begin
          display_done_s = 1'b1;
          if (shift_done_r) begin
            state_s    = GAP_STATE;
            dead_cnt_s = {DC_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          disp_cnt_s = disp_cnt_r + ON_W'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, slot counters and panel-side output registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      dead_cnt_r     <= {DC_W{1'b0}};
      disp_cnt_r     <= {ON_W{1'b0}};
      display_done_r <= 1'b1;
      on_time_r      <= {ON_W{1'b0}};
      plane_r        <= {PL_W{1'b0}};
      row_r          <= {ROW_ADDR_WIDTH{1'b0}};
      row_active_r   <= {ROW_ADDR_WIDTH{1'b0}};
      mask_r         <= {BITPLANES{1'b0}};
      latch_r        <= 1'b0;
      frame_r        <= 1'b0;
      oe_r           <= 1'b0;
    end else begin
      state_r        <= state_s;
      dead_cnt_r     <= dead_cnt_s;
      disp_cnt_r     <= disp_cnt_s;
      display_done_r <= display_done_s;
      latch_r        <= (state_s == ST_LATCH);
      frame_r        <= (state_s == ST_LATCH) && (plane_r == {PL_W{1'b0}}) &&
                        (row_r == {ROW_ADDR_WIDTH{1'b0}});
      oe_r           <= (state_s == ST_DISPLAY) && enable;
      if (state_r == ST_LATCH) begin
        row_active_r <= row_r;
        mask_r       <= BITPLANES'(1'b1) << plane_r;
        on_time_r    <= on_calc_s;
        if (plane_r == PL_LAST) begin
          plane_r <= {PL_W{1'b0}};
          row_r   <= row_r + ROW_ADDR_WIDTH'(1'b1);
        end else begin
          plane_r <= plane_r + PL_W'(1'b1);
        end
      end else begin
        on_time_r <= on_time_r;
      end
    end
  end

  assign column_address     = col_r;
  assign row_address        = row_r;
  assign row_address_active = row_active_r;
  assign brightness_mask    = mask_r;
  assign clk_pixel_load     = load_r;
  assign clk_pixel          = pix_r;
  assign row_latch          = latch_r;
  assign output_enable      = oe_r;
  assign frame_start        = frame_r;

endmodule

// File: tb/tb_hub75_scan_engine.sv
// Self-checking bench for hub75_scan_engine: per-cycle comparison against a slot-timeline model.
module tb_hub75_scan_engine;

  localparam int C     = 4;
  localparam int RW    = 2;
  localparam int NP    = 3;
  localparam int BASE  = 8;
  localparam int FL    = 1;
  localparam int DEAD  = 1;
  localparam int P     = FL + 2;
  localparam int NSLOT = NP * (1 << RW);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    column_address;
  logic [RW-1:0] row_address, row_address_active;
  logic [NP-1:0] brightness_mask;
  logic          clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start;
`ifdef SCAN_GLOBAL_DIM_EN
  logic [7:0]    dim = 8'd255;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the slot timeline: cycle t counts from the first cycle after release
  int t, sh_start, lat_next, lat_prev, on_prev, slot_next, act_row, act_mask;

  always #5 clk = ~clk;

  hub75_scan_engine #(
    .COLUMNS(C), .ROW_ADDR_WIDTH(RW), .BITPLANES(NP),
    .BASE_ON_CYCLES(BASE), .FETCH_LATENCY(FL), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk_in(clk), .reset(reset), .enable(enable),
`ifdef SCAN_GLOBAL_DIM_EN
    .dim(dim),
`endif
    .column_address(column_address), .row_address(row_address),
    .row_address_active(row_address_active), .brightness_mask(brightness_mask),
    .clk_pixel_load(clk_pixel_load), .clk_pixel(clk_pixel), .row_latch(row_latch),
    .output_enable(output_enable), .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int on_time(input int p);
    int base;
    int v;
    base = BASE << p;
`ifdef SCAN_GLOBAL_DIM_EN
    v = (base * (int'(dim) + 1)) >> 8;
    if (v < 1) v = 1;
`else
    v = base;
`endif
    return v;
  endfunction

  task automatic model_reset();
    t         = 0;
    sh_start  = 0;
    lat_next  = C * P + DEAD + 1;
    lat_prev  = -1000;
    on_prev   = 0;
    slot_next = 0;
    act_row   = 0;
    act_mask  = 0;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start,
                column_address, row_address, row_address_active, brightness_mask});
  endfunction

  // Compare one cycle against the model, then advance the model past a latch
  task automatic step_check();
    int          off;
    int          e_col;
    logic        e_load, e_clk, e_oe, e_latch, e_frame;
    logic [31:0] e_shift, o_shift, e_disp, o_disp;
    if (t >= sh_start && t < sh_start + C * P) begin
      off    = t - sh_start;
      e_col  = off / P;
      e_load = (off % P) == 0;
      e_clk  = (off % P) == P - 1;
    end else begin
      e_col  = C - 1;
      e_load = 1'b0;
      e_clk  = 1'b0;
    end
    e_oe    = enable && (t >= lat_prev + 1 + DEAD) && (t <= lat_prev + DEAD + on_prev);
    e_latch = (t == lat_next);
    e_frame = e_latch && (slot_next == 0);
    e_shift = {14'd0, e_load, e_clk, 8'(e_col), 8'(slot_next / NP)};
    o_shift = {14'd0, clk_pixel_load, clk_pixel, 8'(column_address), 8'(row_address)};
    e_disp  = {13'd0, e_latch, e_frame, e_oe, 8'(act_row), 8'(act_mask)};
    o_disp  = {13'd0, row_latch, frame_start, output_enable, 8'(row_address_active), 8'(brightness_mask)};
    check($sformatf("shift@t%0d", t), o_shift, e_shift);
    check($sformatf("disp@t%0d", t), o_disp, e_disp);
    if (e_latch) begin
      lat_prev  = t;
      on_prev   = on_time(slot_next % NP);
      act_row   = slot_next / NP;
      act_mask  = 1 << (slot_next % NP);
      slot_next = (slot_next + 1) % NSLOT;
      sh_start  = t + 1;
      lat_next  = imax(t + 1 + C * P, t + DEAD + on_prev) + DEAD + 1;
    end
    t++;
  endtask

  task automatic release_reset();
`ifdef SCAN_GLOBAL_DIM_EN
    dim = 8'($urandom_range(0, 255));
`endif
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step_check();
      enable = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic reset_hold_check(input string tag);
    #2 reset = 1'b0;
    #1 check({tag, "_async"}, all_outputs(), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, all_outputs(), 32'd0);
  endtask

  initial begin
    bit found;
    int stop_at;
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", all_outputs(), 32'd0);

    // First scan with steady enable, then randomised enable
    release_reset();
    run_cycles(1);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      step_check();
    end
    run_cycles(400);

    // Reset in the middle of shifting column 2 of a non-first slot
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      step_check();
      if (slot_next != 0 && (t - 1) >= sh_start && (t - 1 - sh_start) / P == 2 &&
          (t - 1) < sh_start + C * P) begin
        found = 1'b1;
      end else begin
        enable = ($urandom_range(0, 7) != 0);
      end
    end
    check("mid_shift_found", 32'(found), 32'd1);
    reset_hold_check("mid_shift_rst");

    release_reset();
    enable = 1'b1;
    run_cycles(300);

    // Reset at a random point, then a further randomised run
    stop_at = $urandom_range(5, 250);
    run_cycles(stop_at);
    reset_hold_check("rand_rst");
    release_reset();
    run_cycles(350);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
